// File: rtl/bram_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_rd_pkg
// Description : Shared types and helpers for the block-RAM stream reader.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_rd_pkg;

  // Command sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Extra FIFO slots beyond the read latency: one for the word being
  // presented and one so a stalled consumer does not stop back-to-back issue.
  localparam int FIFO_SLACK = 2;

  // Return-FIFO depth needed to absorb every word in flight
  function automatic int fifo_depth_f(input int read_latency);
    return read_latency + FIFO_SLACK;
  endfunction

  // Only the raw (1) and output-registered (2) RAM configurations exist
  function automatic bit read_latency_ok(input int read_latency);
    return (read_latency == 1) || (read_latency == 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Small synchronous first-word-fall-through FIFO. The head word
//               is visible on data_o whenever empty_o is low.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == c_FULL_CNT);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];

  // A pop on an empty FIFO is ignored; a push while full is only taken when a
  // pop frees the head slot in the same cycle.
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  // Storage array, written at the tail pointer
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rstb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // A write into a full FIFO without a matching pop means upstream credit broke
  always_ff @(posedge clk) begin
    if (!rstb) begin
      assert (!(push_i && full_o && !w_do_pop));
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_reader
// Description : Reads a (base, length) block from a simple-dual-port RAM and
//               presents it as a valid/ready stream with a last marker.
//               Issue is credit-limited so the return FIFO cannot overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_stream_reader
  import bram_rd_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 512,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_en_o,
  output logic              ram_oreg_en_o,
  output logic              ram_rst_o,
  input  logic [WIDTH-1:0]  ram_data_i,
  output logic [WIDTH-1:0]  m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o
);

  localparam int FIFO_DEPTH = fifo_depth_f(READ_LATENCY);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam bit c_LAT_OK   = read_latency_ok(READ_LATENCY);
  localparam logic [CNT_W:0]    c_FIFO_DEPTH = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   c_LEN_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] c_ADDR_ONE   = ADDR_W'(1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_W-1:0]       r_addr;
  logic [ADDR_W:0]         r_len;
  logic [ADDR_W:0]         r_issued;
  logic [ADDR_W:0]         r_beat;
  logic [READ_LATENCY-1:0] r_sr;
  logic                    r_done;
  logic                    w_issue;
  logic                    w_accept;
  logic                    w_zero_len;
  logic                    w_beat;
  logic                    w_final_beat;
  logic                    w_credit;
  logic [CNT_W:0]          w_inflight;
  logic [CNT_W:0]          w_credit_sum;
  logic [WIDTH-1:0]        w_fifo_data;
  logic                    w_fifo_empty;
  logic                    w_fifo_full;
  logic [CNT_W-1:0]        w_fifo_count;

  assign ram_oreg_en_o = 1'b1;
  assign ram_rst_o     = rstb;
  assign ram_en_o      = w_issue;
  assign ram_addr_o    = r_addr;
  assign busy_o        = (r_state != IDLE);
  assign done_o        = r_done;
  assign m_valid_o     = !w_fifo_empty;
  assign m_data_o      = w_fifo_data;
  assign m_last_o      = m_valid_o && (r_beat == (r_len - c_LEN_ONE));

  assign w_accept     = (r_state == IDLE) && start_i && (len_i != '0);
  assign w_zero_len   = (r_state == IDLE) && start_i && (len_i == '0);
  assign w_beat       = m_valid_o && m_ready_i;
  assign w_final_beat = w_beat && m_last_o;

  // Count reads still travelling through the RAM pipeline
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + (CNT_W + 1)'(r_sr[i]);
    end
  end

  // Issue only while every outstanding word is guaranteed a FIFO slot
  always_comb begin
    w_credit_sum = w_inflight + (CNT_W + 1)'(w_fifo_count);
    w_credit     = (w_credit_sum < c_FIFO_DEPTH) && !w_fifo_full;
  end

  // Next-state and read-issue decision
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_issued == r_len) begin
          w_state_nxt = DRAIN;
        end else if (w_credit) begin
          w_issue = 1'b1;
          if ((r_issued + c_LEN_ONE) == r_len) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_final_beat) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and completion pulse
  always_ff @(posedge clk) begin
    if (rstb) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_zero_len || ((r_state == DRAIN) && w_final_beat);
    end
  end

  // Command latch, running read pointer and issue/beat counters
  always_ff @(posedge clk) begin
    if (rstb) begin
      r_addr   <= '0;
      r_len    <= '0;
      r_issued <= '0;
      r_beat   <= '0;
    end else if (w_accept) begin
      r_addr   <= base_addr_i;
      r_len    <= len_i;
      r_issued <= '0;
      r_beat   <= '0;
    end else begin
      if (w_issue) begin
        r_addr   <= r_addr + c_ADDR_ONE;
        r_issued <= r_issued + c_LEN_ONE;
      end
      if (w_beat) begin
        r_beat <= r_beat + c_LEN_ONE;
      end
    end
  end

  // In-flight shift register: the tail bit marks valid RAM data this cycle
  if (READ_LATENCY == 1) begin : g_sr_single
    always_ff @(posedge clk) begin
      if (rstb) begin
        r_sr <= '0;
      end else begin
        r_sr <= w_issue;
      end
    end
  end else begin : g_sr_multi
    always_ff @(posedge clk) begin
      if (rstb) begin
        r_sr <= '0;
      end else begin
        r_sr <= {r_sr[READ_LATENCY-2:0], w_issue};
      end
    end
  end

  // Catch an illegal latency configuration in simulation
  always_ff @(posedge clk) begin
    assert (c_LAT_OK);
  end

  sync_fifo_fwft #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstb    (rstb),
    .push_i  (r_sr[READ_LATENCY-1]),
    .data_i  (ram_data_i),
    .pop_i   (w_beat),
    .data_o  (w_fifo_data),
    .empty_o (w_fifo_empty),
    .full_o  (w_fifo_full),
    .count_o (w_fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_stream_reader
// Description : Directed bench for bram_stream_reader. Two instances run side
//               by side, READ_LATENCY 1 (index 0) and 2 (index 1), each fed by
//               a RAM model whose word at address a is a.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_stream_reader;

  localparam int W  = 32;
  localparam int D  = 128;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic rstb;

  logic [1:0]    start, busy, done, ram_en, ram_oreg_en, ram_rst;
  logic [1:0]    m_valid, m_ready, m_last;
  logic [AW-1:0] base_addr [2];
  logic [AW-1:0] ram_addr  [2];
  logic [AW:0]   len       [2];
  logic [W-1:0]  ram_data  [2];
  logic [W-1:0]  m_data    [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    logic [W-1:0] q1, q2;

    bram_stream_reader #(
      .WIDTH        (W),
      .DEPTH        (D),
      .READ_LATENCY (i + 1)
    ) u_dut (
      .clk           (clk),
      .rstb          (rstb),
      .start_i       (start[i]),
      .base_addr_i   (base_addr[i]),
      .len_i         (len[i]),
      .busy_o        (busy[i]),
      .done_o        (done[i]),
      .ram_addr_o    (ram_addr[i]),
      .ram_en_o      (ram_en[i]),
      .ram_oreg_en_o (ram_oreg_en[i]),
      .ram_rst_o     (ram_rst[i]),
      .ram_data_i    (ram_data[i]),
      .m_data_o      (m_data[i]),
      .m_valid_o     (m_valid[i]),
      .m_ready_i     (m_ready[i]),
      .m_last_o      (m_last[i])
    );

    // RAM model: registered read, optional output register
    always @(posedge clk) begin
      if (ram_en[i]) q1 <= W'(ram_addr[i]);
      q2 <= q1;
    end

    if (i == 0) begin : g_lat1
      assign ram_data[i] = q1;
    end else begin : g_lat2
      assign ram_data[i] = q2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int d);
    chk("rst_busy",  busy[d],     0);
    chk("rst_done",  done[d],     0);
    chk("rst_en",    ram_en[d],   0);
    chk("rst_addr",  ram_addr[d], 0);
    chk("rst_valid", m_valid[d],  0);
    chk("rst_last",  m_last[d],   0);
    chk("rst_oreg",  ram_oreg_en[d], 1);
  endtask

  // Ready held high: issue cycles 1..l, valid cycles rl+2..rl+1+l, done after
  task automatic run_directed(input int d, input int b, input int l);
    int rl;
    bit vexp;
    rl = d + 1;
    @(negedge clk);
    start[d] = 1'b1; base_addr[d] = AW'(b); len[d] = (AW + 1)'(l); m_ready[d] = 1'b1;
    for (int c = 1; c <= rl + l + 4; c++) begin
      @(negedge clk);
      start[d] = 1'b0;
      chk("dir_en", ram_en[d], 32'(c <= l));
      if (c <= l) chk("dir_addr", ram_addr[d], (b + c - 1) % D);
      vexp = (c >= rl + 2) && (c <= rl + 1 + l);
      chk("dir_valid", m_valid[d], 32'(vexp));
      if (vexp) chk("dir_data", m_data[d], (b + c - rl - 2) % D);
      chk("dir_last", m_last[d], 32'(c == rl + 1 + l));
      chk("dir_done", done[d],   32'(c == rl + 2 + l));
      chk("dir_busy", busy[d],   32'(c <= rl + 1 + l));
    end
  endtask

  // len=64 with ~40% ready duty; checks order, stability, credit and completion
  task automatic run_random(input int d, input int b);
    int issued, beats, dones, rl;
    bit prev_stall;
    logic [W-1:0] pd;
    logic pl;
    issued = 0; beats = 0; dones = 0; rl = d + 1; prev_stall = 0; pd = '0; pl = 0;
    @(negedge clk);
    start[d] = 1'b1; base_addr[d] = AW'(b); len[d] = (AW + 1)'(64); m_ready[d] = 1'b0;
    for (int cyc = 1; cyc <= 3000 && dones == 0; cyc++) begin
      @(negedge clk);
      start[d] = 1'b0;
      if (ram_en[d]) begin
        chk("rnd_addr", ram_addr[d], (b + issued) % D);
        issued++;
        chk("rnd_credit", 32'((issued - beats) <= rl + 2), 1);
      end
      if (prev_stall) begin
        chk("rnd_hold_valid", m_valid[d], 1);
        chk("rnd_hold_data",  m_data[d],  pd);
        chk("rnd_hold_last",  m_last[d],  32'(pl));
      end
      if (done[d]) dones++;
      m_ready[d] = ($urandom_range(0, 99) < 40);
      if (m_valid[d] && m_ready[d]) begin
        chk("rnd_data", m_data[d], (b + beats) % D);
        chk("rnd_last", m_last[d], 32'(beats == 63));
        beats++;
      end
      prev_stall = m_valid[d] && !m_ready[d];
      pd = m_data[d];
      pl = m_last[d];
    end
    chk("rnd_beats",  beats,  64);
    chk("rnd_issued", issued, 64);
    chk("rnd_dones",  dones,  1);
    m_ready[d] = 1'b1;
  endtask

  initial begin
    int dones;
    rstb = 1'b1;
    start = '0;
    m_ready = '0;
    for (int d = 0; d < 2; d++) begin
      base_addr[d] = '0;
      len[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk_reset(d);
      chk("rst_ramrst_hi", ram_rst[d], 1);
    end
    rstb = 1'b0;

    // Basic read, latency 1, and wrapping read, latency 2
    run_directed(0, 5, 4);
    run_directed(1, D - 2, 4);

    // Zero-length command on both latencies
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      start[d] = 1'b1; base_addr[d] = AW'(9); len[d] = '0;
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        start[d] = 1'b0;
        chk("len0_done",  done[d],    32'(c == 1));
        chk("len0_en",    ram_en[d],  0);
        chk("len0_valid", m_valid[d], 0);
        chk("len0_busy",  busy[d],    0);
      end
      chk("len0_ramrst_lo", ram_rst[d], 0);
    end

    // Backpressured long reads, with address wrap
    run_random(0, 100);
    run_random(1, 90);

    // Reset in the middle of a command, ready low so credit stalls after 3
    @(negedge clk);
    start[0] = 1'b1; base_addr[0] = AW'(20); len[0] = (AW + 1)'(10); m_ready[0] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
      chk("mid_en", ram_en[0], 32'(c <= 3));
      if (c <= 3) chk("mid_addr", ram_addr[0], 20 + c - 1);
    end
    rstb = 1'b1;
    @(negedge clk);
    chk_reset(0);
    rstb = 1'b0;
    run_directed(0, 0, 2);

    // Start pulsed during DRAIN is ignored
    @(negedge clk);
    start[1] = 1'b1; base_addr[1] = AW'(10); len[1] = (AW + 1)'(3); m_ready[1] = 1'b1;
    dones = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start[1] = (c == 5);
      if (c == 5) begin
        base_addr[1] = AW'(50);
        len[1] = (AW + 1)'(5);
        chk("drain_busy", busy[1], 1);
      end
      chk("drain_en", ram_en[1], 32'(c <= 3));
      if (c >= 4 && c <= 6) chk("drain_data", m_data[1], 10 + c - 4);
      if (done[1]) dones++;
    end
    start[1] = 1'b0;
    chk("drain_single_done", dones, 1);
    run_directed(1, 50, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
